uart_rx_fifo: RTL and testbench

Synthesizable UART receiver for the TinyQV peripheral bus, feeding received bytes to the CPU through a small FIFO. It is the receive-direction counterpart of the existing UART TX path, using the same 8N1 framing and the same clocks-per-bit timing (217 clocks at 25 MHz for 115200 baud). The input comes from a ui_in pin, and the outputs connect to the peripheral register block (data, valid and status).

---
 rtl/uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small receive FIFO for the TinyQV bus.
// Optional 8E1 framing with a sticky parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          clr_err,
    output logic                          busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              rxd_meta_q, rxd_meta_d;
    logic              rxd_s_q, rxd_s_d;
    logic              rxd_prev_q, rxd_prev_d;
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              fall, push, frame_set, pop, full, push_ok, ovr_set;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
    logic              parity_set;
`endif

    // Synchronizer and start-edge detection. Edges are only honoured once a
    // real high level has come through the chain, so a line held low across
    // reset release is not mistaken for a start bit.
    always_comb begin
        rxd_meta_d = rxd;
        rxd_s_d    = rxd_meta_q;
        rxd_prev_d = rxd_s_q;
        settle_d   = {settle_q[0], 1'b1};
        armed_d    = armed_q | (settle_q[1] & rxd_s_q);
        fall       = armed_q & rxd_prev_q & ~rxd_s_q;
    end

    // Receive FSM next-state: bit timing, sampling and error detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rxd_s_q) begin
                    cnt_d     = CNT_FULL;
                    bit_idx_d = '0;
                    state_d   = DATA;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d   = {rxd_s_q, shift_q[7:1]};
                    cnt_d     = CNT_FULL;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    par_bad_d  = ^{shift_q, rxd_s_q};
                    parity_set = ^{shift_q, rxd_s_q};
                    cnt_d      = CNT_FULL;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rxd_s_q) begin
`ifdef UART_RX_PARITY_EN
                    push = ~par_bad_q;
`else
                    push = 1'b1;
`endif
                    state_d = IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rxd_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, storage and sticky flags; a pop frees room for a same-cycle push.
    always_comb begin
        pop      = rx_valid & rx_ready;
        full     = (rx_count == PW'(FIFO_DEPTH));
        push_ok  = push & (~full | pop);
        ovr_set  = push & full & ~pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        frame_err_d = (frame_err_q & ~clr_err) | frame_set;
        overrun_d   = (overrun_q & ~clr_err) | ovr_set;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q & ~clr_err) | parity_set;
`endif
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_prev_q  <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '{default: '0};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rxd_meta_q  <= rxd_meta_d;
            rxd_s_q     <= rxd_s_d;
            rxd_prev_q  <= rxd_prev_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Output decode.
    always_comb begin
        rx_count  = wr_ptr_q - rd_ptr_q;
        rx_valid  = (wr_ptr_q != rd_ptr_q);
        rx_data   = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        frame_err = frame_err_q;
        overrun   = overrun_q;
        busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
        parity_err = parity_err_q;
`endif
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-based bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;
    logic       clr_err = 1'b0;
    logic       busy;

    int         chk_total = 0;
    int         chk_pass  = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_pop;
    logic [7:0] stop_pop_data;
    logic       valid_pre, valid_post;
    logic       exp_overrun = 1'b0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_count(rx_count), .frame_err(frame_err),
        .overrun(overrun), .clr_err(clr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; act 1 pops and act 2 pulses clr_err in the stop-bit sample cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int act);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd = bits[b];
            for (int k = 0; k < CPB; k++) begin
                @(posedge clk);
                #1;
                if (b == 9 && k == 9) begin
                    valid_pre = rx_valid;
                    if (act == 1) begin
                        stop_pop_data = rx_data;
                        rx_ready = 1'b1;
                    end
                    if (act == 2) clr_err = 1'b1;
                end
                if (b == 9 && k == 10) begin
                    valid_post = rx_valid;
                    rx_ready   = 1'b0;
                    clr_err    = 1'b0;
                end
            end
        end
        if (act == 1) exp_pop = sb.pop_front();
        if (stop) begin
            if (sb.size() < DEPTH) sb.push_back(d);
            else exp_overrun = 1'b1;
        end
    endtask

    task automatic test_reset();
        tick(3);
        chk_total++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rx_valid); else chk_pass++;
        chk_total++; if (rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_data); else chk_pass++;
        chk_total++; if (rx_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", rx_count); else chk_pass++;
        chk_total++; if ({frame_err, overrun, busy} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {frame_err, overrun, busy}); else chk_pass++;
        rst = 1'b0;
        tick(10);
    endtask

    task automatic test_single();
        send_frame(8'h55, 1'b1, 0);
        chk_total++; if ({valid_pre, valid_post} !== 2'b01) $display("FAIL single_latency got=%b exp=01", {valid_pre, valid_post}); else chk_pass++;
        chk_total++; if (rx_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", rx_valid); else chk_pass++;
        chk_total++; if (rx_data !== sb[0]) $display("FAIL single_data got=%h exp=%h", rx_data, sb[0]); else chk_pass++;
        chk_total++; if (rx_count !== 3'd1) $display("FAIL single_count got=%0d exp=1", rx_count); else chk_pass++;
        chk_total++; if ({frame_err, busy} !== 2'b00) $display("FAIL single_flags got=%b exp=00", {frame_err, busy}); else chk_pass++;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        void'(sb.pop_front());
        chk_total++; if ({rx_valid, rx_data} !== 9'h000) $display("FAIL single_pop got=%b/%h exp=0/00", rx_valid, rx_data); else chk_pass++;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk_total++; if (rx_count !== 3'd0) $display("FAIL empty_pop_count got=%0d exp=0", rx_count); else chk_pass++;
        tick(16);
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        tick(4);
        chk_total++; if (busy !== 1'b1) $display("FAIL glitch_busy got=%b exp=1", busy); else chk_pass++;
        tick(1);
        rxd = 1'b1;
        tick(30);
        chk_total++; if (busy !== 1'b0) $display("FAIL glitch_idle got=%b exp=0", busy); else chk_pass++;
        chk_total++; if (rx_count !== 3'd0) $display("FAIL glitch_count got=%0d exp=0", rx_count); else chk_pass++;
        chk_total++; if ({frame_err, overrun} !== 2'b00) $display("FAIL glitch_flags got=%b exp=00", {frame_err, overrun}); else chk_pass++;
    endtask

    task automatic test_frame_err();
        send_frame(8'hA3, 1'b0, 2);
        chk_total++; if (frame_err !== 1'b1) $display("FAIL ferr_set_wins got=%b exp=1", frame_err); else chk_pass++;
        chk_total++; if ({rx_valid, rx_count} !== 4'h0) $display("FAIL ferr_nopush got=%b/%0d exp=0/0", rx_valid, rx_count); else chk_pass++;
        tick(5 * CPB);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk_total++; if (frame_err !== 1'b0) $display("FAIL ferr_clear got=%b exp=0", frame_err); else chk_pass++;
        tick(35 * CPB);
        chk_total++; if ({frame_err, busy} !== 2'b01) $display("FAIL ferr_break_once got=%b exp=01", {frame_err, busy}); else chk_pass++;
        rxd = 1'b1;
        tick(2 * CPB);
        chk_total++; if ({frame_err, busy, rx_count} !== 5'b0) $display("FAIL ferr_recover got=%b/%b/%0d exp=0/0/0", frame_err, busy, rx_count); else chk_pass++;
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
        chk_total++; if (rx_count !== 3'd4) $display("FAIL ovr_count got=%0d exp=4", rx_count); else chk_pass++;
        chk_total++; if (overrun !== exp_overrun) $display("FAIL ovr_flag got=%b exp=%b", overrun, exp_overrun); else chk_pass++;
        while (sb.size() > 0) begin
            chk_total++; if (rx_data !== sb[0]) $display("FAIL ovr_order got=%h exp=%h", rx_data, sb[0]); else chk_pass++;
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            void'(sb.pop_front());
        end
        chk_total++; if ({rx_valid, rx_count} !== 4'h0) $display("FAIL ovr_drained got=%b/%0d exp=0/0", rx_valid, rx_count); else chk_pass++;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        exp_overrun = 1'b0;
        chk_total++; if (overrun !== 1'b0) $display("FAIL ovr_clear got=%b exp=0", overrun); else chk_pass++;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 0);
        send_frame(8'h14, 1'b1, 1);
        chk_total++; if (stop_pop_data !== exp_pop) $display("FAIL fullpop_head got=%h exp=%h", stop_pop_data, exp_pop); else chk_pass++;
        chk_total++; if (overrun !== exp_overrun) $display("FAIL fullpop_ovr got=%b exp=%b", overrun, exp_overrun); else chk_pass++;
        chk_total++; if (rx_count !== 3'(sb.size())) $display("FAIL fullpop_count got=%0d exp=%0d", rx_count, sb.size()); else chk_pass++;
        while (sb.size() > 0) begin
            chk_total++; if (rx_data !== sb[0]) $display("FAIL fullpop_order got=%h exp=%h", rx_data, sb[0]); else chk_pass++;
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            void'(sb.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] part;
        part = 8'h3C;
        rxd = 1'b0;
        tick(CPB);
        for (int b = 0; b < 4; b++) begin
            rxd = part[b];
            tick(CPB);
        end
        rxd = part[4];
        tick(CPB / 2);
        rst = 1'b1;
        rxd = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk_total++; if ({busy, rx_count} !== 4'h0) $display("FAIL rstmid_clear got=%b/%0d exp=0/0", busy, rx_count); else chk_pass++;
        send_frame(8'hC3, 1'b1, 0);
        chk_total++; if (rx_count !== 3'd1) $display("FAIL rstmid_count got=%0d exp=1", rx_count); else chk_pass++;
        chk_total++; if (rx_data !== sb[0]) $display("FAIL rstmid_data got=%h exp=%h", rx_data, sb[0]); else chk_pass++;
        chk_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else chk_pass++;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        void'(sb.pop_front());
        rxd = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(40);
        chk_total++; if (busy !== 1'b0) $display("FAIL low_at_release got=%b exp=0", busy); else chk_pass++;
        rxd = 1'b1;
        tick(20);
        chk_total++; if ({busy, rx_valid, frame_err} !== 3'b000) $display("FAIL low_release_after got=%b exp=000", {busy, rx_valid, frame_err}); else chk_pass++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end
endmodule
